// File: rtl/quadrature_paddle.sv
// quadrature_paddle
//
// Front end for one player's rotary encoder. It synchronises the two raw
// encoder pins, debounces each pin on its own, and decodes the quadrature
// transitions. It turns full detents into a saturating paddle position and
// single-cycle step pulses for the pong core.
//
// Ports:
//   clk        system clock (pixel clock); all state changes on its rising edge
//   reset      asynchronous, active-low reset
//   enc_a      raw encoder pin A (asynchronous to clk)
//   enc_b      raw encoder pin B (asynchronous to clk)
//   enable     when low, position is frozen and steps are discarded
//   position   registered paddle position, clamped to [POS_MIN, POS_MAX]
//   step_up    one-cycle pulse per completed clockwise detent
//   step_down  one-cycle pulse per completed counter-clockwise detent
//   error      one-cycle pulse when both debounced pins change in the same cycle

module quadrature_paddle #(
    parameter int DEBOUNCE_CYCLES      = 1024,
    parameter int TRANSITIONS_PER_STEP = 4,
    parameter int POS_WIDTH            = 5,
    parameter int POS_MIN              = 0,
    parameter int POS_MAX              = 28,
    parameter int INIT_POS             = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enable,
    output logic [POS_WIDTH-1:0] position,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 error
);

    // The debounce counter only has to count to DEBOUNCE_CYCLES-1. On that
    // count, the next mismatching cycle commits the new value.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [POS_WIDTH-1:0] P_MIN  = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0] P_MAX  = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] P_INIT = POS_WIDTH'(INIT_POS);

    // Step thresholds are held in 4 bits. +4 does not fit in the 3-bit
    // accumulator, so it is only seen on the widened sum.
    localparam logic signed [3:0] ACC_TOP = 4'(TRANSITIONS_PER_STEP);
    localparam logic signed [3:0] ACC_BOT = 4'(-TRANSITIONS_PER_STEP);

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_FWD,
        MOVE_REV,
        MOVE_ILLEGAL
    } move_t;

    // Bit 1 is pin A and bit 0 is pin B throughout.
    logic [1:0]           sync1;
    logic [1:0]           sync2;
    logic [1:0]           deb;
    logic [CNT_W-1:0]     cnt [2];
    logic [1:0]           ab_q;
    logic signed [2:0]    acc;

    move_t                move;
    logic signed [3:0]    acc_sum;
    logic signed [2:0]    acc_next;
    logic [POS_WIDTH-1:0] pos_next;
    logic                 up_next;
    logic                 down_next;
    logic                 err_next;

    // Two-flop synchroniser per pin. Reset to 1 because the pins idle high
    // at a detent, so releasing reset at rest produces no transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

    // Independent debouncer per pin. A pin's debounced value changes only
    // after the synchronised value has disagreed with it for DEBOUNCE_CYCLES
    // cycles in a row. Any cycle of agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Classify the move from the previous debounced pair to the current one.
    // The forward cycle is 00 -> 10 -> 11 -> 01 -> 00. If both bits flip at
    // once the direction cannot be known.
    always_comb begin
        move = MOVE_NONE;
        case ({ab_q, deb})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MOVE_FWD;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: move = MOVE_REV;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: move = MOVE_ILLEGAL;
            default:                                move = MOVE_NONE;
        endcase
    end

    // Accumulate valid transitions. When a full detent is reached in either
    // direction, emit the step pulse and move the position, clamped to the
    // paddle range. With enable low the accumulator is held at zero, so no
    // partial detent survives into re-enable. error is still reported.
    always_comb begin
        acc_sum   = 4'(acc);
        acc_next  = acc;
        pos_next  = position;
        up_next   = 1'b0;
        down_next = 1'b0;
        err_next  = (move == MOVE_ILLEGAL);

        if (!enable) begin
            acc_next = '0;
        end else if (move == MOVE_FWD || move == MOVE_REV) begin
            if (move == MOVE_FWD) begin
                acc_sum = 4'(acc) + 4'sd1;
            end else begin
                acc_sum = 4'(acc) - 4'sd1;
            end

            if (acc_sum == ACC_TOP) begin
                up_next  = 1'b1;
                acc_next = '0;
                if (position < P_MAX) begin
                    pos_next = position + POS_WIDTH'(1);
                end
            end else if (acc_sum == ACC_BOT) begin
                down_next = 1'b1;
                acc_next  = '0;
                if (position > P_MIN) begin
                    pos_next = position - POS_WIDTH'(1);
                end
            end else begin
                acc_next = acc_sum[2:0];
            end
        end
    end

    // Decoder state and registered outputs. ab_q follows the debounced pair
    // even while disabled, so re-enabling never sees a stale transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ab_q      <= 2'b11;
            acc       <= '0;
            position  <= P_INIT;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            error     <= 1'b0;
        end else begin
            ab_q      <= deb;
            acc       <= acc_next;
            position  <= pos_next;
            step_up   <= up_next;
            step_down <= down_next;
            error     <= err_next;
        end
    end

endmodule

// File: tb/tb_quadrature_paddle.sv
// tb_quadrature_paddle
//
// Directed self-checking bench for quadrature_paddle with DEBOUNCE_CYCLES=4
// and TRANSITIONS_PER_STEP=4. A negedge monitor counts output pulses, and
// each scenario task compares the count deltas and the position against
// hand-computed values.

module tb_quadrature_paddle;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       enable;
    logic [4:0] position;
    logic       step_up;
    logic       step_down;
    logic       error;

    int total = 0;
    int bad   = 0;

    int cycle         = 0;
    int up_total      = 0;
    int dn_total      = 0;
    int err_total     = 0;
    int overlap_total = 0;
    int last_up_cycle = -1;

    quadrature_paddle #(
        .DEBOUNCE_CYCLES      (4),
        .TRANSITIONS_PER_STEP (4),
        .POS_WIDTH            (5),
        .POS_MIN              (0),
        .POS_MAX              (28),
        .INIT_POS             (14)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enable    (enable),
        .position  (position),
        .step_up   (step_up),
        .step_down (step_down),
        .error     (error)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Count rising edges so pulse latency can be measured
    always @(posedge clk) begin
        cycle++;
    end

    // Pulse monitor, sampled on the falling edge away from the active edge
    always @(negedge clk) begin
        if (step_up === 1'b1) begin
            up_total++;
            last_up_cycle = cycle;
        end
        if (step_down === 1'b1) dn_total++;
        if (error === 1'b1) err_total++;
        if ((int'(step_up === 1'b1) + int'(step_down === 1'b1) + int'(error === 1'b1)) > 1)
            overlap_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic a, input logic b, input int hold);
        enc_a = a;
        enc_b = b;
        tick(hold);
    endtask

    task automatic detent_cw();
        set_pins(1'b0, 1'b1, 10);
        set_pins(1'b0, 1'b0, 10);
        set_pins(1'b1, 1'b0, 10);
        set_pins(1'b1, 1'b1, 10);
    endtask

    task automatic detent_ccw();
        set_pins(1'b1, 1'b0, 10);
        set_pins(1'b0, 1'b0, 10);
        set_pins(1'b0, 1'b1, 10);
        set_pins(1'b1, 1'b1, 10);
    endtask

    task automatic reset_dut();
        enc_a  = 1'b1;
        enc_b  = 1'b1;
        enable = 1'b1;
        reset  = 1'b0;
        tick(3);
        reset  = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        int b_up, b_dn, b_err;
        total++;
        if (position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL reset_position: got %0d want 14", position);
        end
        total++;
        if ({step_up, step_down, error} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_pulses: got %b want 000", {step_up, step_down, error});
        end
        reset = 1'b1;
        tick(2);
        detent_cw();
        total++;
        if (position !== 5'd15) begin
            bad++;
            $display("[TB] FAIL pre_reset_position: got %0d want 15", position);
        end
        enc_a = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
        total++;
        if (position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL async_reset_position: got %0d want 14", position);
        end
        enc_a = 1'b1;
        tick(3);
        reset = 1'b1;
        b_up = up_total; b_dn = dn_total; b_err = err_total;
        tick(20);
        total++;
        if ((up_total - b_up) + (dn_total - b_dn) + (err_total - b_err) !== 0) begin
            bad++;
            $display("[TB] FAIL post_reset_pulses: got %0d want 0",
                     (up_total - b_up) + (dn_total - b_dn) + (err_total - b_err));
        end
        total++;
        if (position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL post_reset_position: got %0d want 14", position);
        end
    endtask

    task automatic test_forward_reverse();
        int b_up, b_dn, b_err, change_cycle;
        b_up = up_total; b_dn = dn_total; b_err = err_total;
        set_pins(1'b0, 1'b1, 10);
        set_pins(1'b0, 1'b0, 10);
        set_pins(1'b1, 1'b0, 10);
        total++;
        if (position !== 5'd14 || up_total !== b_up) begin
            bad++;
            $display("[TB] FAIL partial_detent: got pos=%0d ups=%0d want pos=14 ups=0",
                     position, up_total - b_up);
        end
        enc_a = 1'b1;
        enc_b = 1'b1;
        change_cycle = cycle;
        tick(10);
        total++;
        if (up_total - b_up !== 1) begin
            bad++;
            $display("[TB] FAIL fwd_step_count: got %0d want 1", up_total - b_up);
        end
        total++;
        if (last_up_cycle - change_cycle !== 7) begin
            bad++;
            $display("[TB] FAIL fwd_latency: got %0d want 7", last_up_cycle - change_cycle);
        end
        total++;
        if (position !== 5'd15) begin
            bad++;
            $display("[TB] FAIL fwd_position: got %0d want 15", position);
        end
        detent_ccw();
        total++;
        if (dn_total - b_dn !== 1) begin
            bad++;
            $display("[TB] FAIL rev_step_count: got %0d want 1", dn_total - b_dn);
        end
        total++;
        if (position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL rev_position: got %0d want 14", position);
        end
        total++;
        if (err_total - b_err !== 0 || up_total - b_up !== 1) begin
            bad++;
            $display("[TB] FAIL fwd_rev_extra: got errs=%0d ups=%0d want errs=0 ups=1",
                     err_total - b_err, up_total - b_up);
        end
    endtask

    task automatic test_glitch();
        int b_up, b_dn, b_err;
        b_up = up_total; b_dn = dn_total; b_err = err_total;
        for (int i = 0; i < 5; i++) begin
            set_pins(1'b0, 1'b1, 3);
            set_pins(1'b1, 1'b1, 5);
        end
        tick(10);
        total++;
        if (up_total - b_up !== 0 || dn_total - b_dn !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_steps: got up=%0d down=%0d want 0",
                     up_total - b_up, dn_total - b_dn);
        end
        total++;
        if (err_total - b_err !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_error: got %0d want 0", err_total - b_err);
        end
        total++;
        if (position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL glitch_position: got %0d want 14", position);
        end
    endtask

    task automatic test_saturation();
        int b_up, b_dn;
        reset_dut();
        b_up = up_total; b_dn = dn_total;
        for (int i = 0; i < 14; i++) detent_cw();
        total++;
        if (position !== 5'd28) begin
            bad++;
            $display("[TB] FAIL reach_max: got %0d want 28", position);
        end
        for (int i = 0; i < 6; i++) detent_cw();
        total++;
        if (position !== 5'd28) begin
            bad++;
            $display("[TB] FAIL hold_max: got %0d want 28", position);
        end
        total++;
        if (up_total - b_up !== 20) begin
            bad++;
            $display("[TB] FAIL sat_up_count: got %0d want 20", up_total - b_up);
        end
        for (int i = 0; i < 40; i++) detent_ccw();
        total++;
        if (position !== 5'd0) begin
            bad++;
            $display("[TB] FAIL hold_min: got %0d want 0", position);
        end
        total++;
        if (dn_total - b_dn !== 40) begin
            bad++;
            $display("[TB] FAIL sat_down_count: got %0d want 40", dn_total - b_dn);
        end
    endtask

    task automatic test_illegal();
        int b_up, b_dn, b_err;
        reset_dut();
        b_up = up_total; b_dn = dn_total; b_err = err_total;
        set_pins(1'b0, 1'b0, 10);
        total++;
        if (err_total - b_err !== 1) begin
            bad++;
            $display("[TB] FAIL illegal_error: got %0d want 1", err_total - b_err);
        end
        total++;
        if (position !== 5'd14 || up_total !== b_up || dn_total !== b_dn) begin
            bad++;
            $display("[TB] FAIL illegal_effect: got pos=%0d up=%0d down=%0d want 14/0/0",
                     position, up_total - b_up, dn_total - b_dn);
        end
        // Accumulator must still be 0: 2 more forward moves give 2, then 3, then the step
        set_pins(1'b1, 1'b0, 10);
        set_pins(1'b1, 1'b1, 10);
        set_pins(1'b0, 1'b1, 10);
        total++;
        if (up_total - b_up !== 0) begin
            bad++;
            $display("[TB] FAIL illegal_acc_early: got %0d want 0", up_total - b_up);
        end
        set_pins(1'b0, 1'b0, 10);
        total++;
        if (up_total - b_up !== 1 || position !== 5'd15) begin
            bad++;
            $display("[TB] FAIL illegal_recover: got up=%0d pos=%0d want 1/15",
                     up_total - b_up, position);
        end
        set_pins(1'b1, 1'b0, 10);
        set_pins(1'b1, 1'b1, 10);
        total++;
        if (err_total - b_err !== 1 || up_total - b_up !== 1) begin
            bad++;
            $display("[TB] FAIL illegal_tail: got err=%0d up=%0d want 1/1",
                     err_total - b_err, up_total - b_up);
        end
    endtask

    task automatic test_enable();
        int b_up, b_dn, b_err;
        reset_dut();
        b_up = up_total; b_dn = dn_total; b_err = err_total;
        set_pins(1'b0, 1'b1, 10);
        set_pins(1'b0, 1'b0, 10);
        set_pins(1'b0, 1'b1, 10);
        set_pins(1'b1, 1'b1, 10);
        total++;
        if (up_total - b_up !== 0 || dn_total - b_dn !== 0 || position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL half_detent: got up=%0d down=%0d pos=%0d want 0/0/14",
                     up_total - b_up, dn_total - b_dn, position);
        end
        enable = 1'b0;
        detent_cw();
        total++;
        if (up_total - b_up !== 0 || position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL disabled_detent: got up=%0d pos=%0d want 0/14",
                     up_total - b_up, position);
        end
        set_pins(1'b0, 1'b0, 10);
        set_pins(1'b1, 1'b1, 10);
        total++;
        if (err_total - b_err !== 2 || position !== 5'd14) begin
            bad++;
            $display("[TB] FAIL disabled_error: got err=%0d pos=%0d want 2/14",
                     err_total - b_err, position);
        end
        enable = 1'b1;
        tick(5);
        total++;
        if (up_total - b_up !== 0 || dn_total - b_dn !== 0) begin
            bad++;
            $display("[TB] FAIL reenable_spurious: got up=%0d down=%0d want 0/0",
                     up_total - b_up, dn_total - b_dn);
        end
        detent_cw();
        total++;
        if (up_total - b_up !== 1 || position !== 5'd15) begin
            bad++;
            $display("[TB] FAIL reenable_step: got up=%0d pos=%0d want 1/15",
                     up_total - b_up, position);
        end
    endtask

    task automatic test_exclusive_pulses();
        total++;
        if (overlap_total !== 0) begin
            bad++;
            $display("[TB] FAIL pulse_overlap: got %0d cycles want 0", overlap_total);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enc_a  = 1'b1;
        enc_b  = 1'b1;
        enable = 1'b1;
        #2;
        reset  = 1'b0;
        tick(2);
        $display("[TB] starting quadrature_paddle scenarios");
        test_reset();
        test_forward_reverse();
        test_glitch();
        test_saturation();
        test_illegal();
        test_enable();
        test_exclusive_pulses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quadrature_paddle.md
# quadrature_paddle

Debounced quadrature-encoder front end that turns one player's rotary-encoder pins (`player*_a`/`player*_b` at the FPGA top) into a saturating paddle position plus single-cycle step pulses for the `pong` game core. One instance per player sits between the board pins and `pong`. It contains the synchroniser, a per-pin debouncer, the quadrature transition decoder and the position counter.

## Interface
- `DEBOUNCE_CYCLES`, 1024: consecutive cycles a synchronised pin must differ from its debounced value before that value updates (≥2).
- `TRANSITIONS_PER_STEP`, 4: valid quadrature transitions per step; legal values 1, 2, 4.
- `POS_WIDTH`, 5: width of `position`.
- `POS_MIN`, 0: lowest position.
- `POS_MAX`, 28: highest position.
- `INIT_POS`, 14: position after reset; POS_MIN ≤ INIT_POS ≤ POS_MAX.

- `clk` in 1: system clock, the 31.5 MHz pixel clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enc_a` in 1: encoder pin A, asynchronous.
- `enc_b` in 1: encoder pin B, asynchronous.
- `enable` in 1: when low, position is frozen and steps are discarded.
- `position` out POS_WIDTH: paddle position, registered.
- `step_up` out 1: one-cycle pulse per completed clockwise step.
- `step_down` out 1: one-cycle pulse per completed counter-clockwise step.
- `error` out 1: one-cycle pulse on an illegal transition (both bits change at once).

## Operation
- **Reset (asserted):**
  - Synchroniser flops and debounced values go to 1, because pins idle high at the detent.
  - Debounced-previous register `ab_q` = 2'b11.
  - Debounce counters = 0; accumulator = 0.
  - `position` = INIT_POS.
  - `step_up`, `step_down`, `error` = 0.
- **Synchroniser:** two flops per pin.
- **Debouncer, per pin, independent:**
  - Synchronised value ≠ debounced value: the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced value takes the synchronised value and the counter clears.
  - Synchronised value = debounced value: the counter clears.
- **Decoder:** AB = {debounced A, debounced B}; compared every cycle against `ab_q`; `ab_q` then updates.
  - Forward (+1): 00→10, 10→11, 11→01, 01→00.
  - Reverse (−1): the inverse of each forward transition.
  - No change: nothing happens.
  - Both bits change: `error` pulses; accumulator and position are unchanged.
- **Accumulator:** 3-bit signed, adds ±1 per valid transition.
  - Reaches +TRANSITIONS_PER_STEP: `step_up` pulses, accumulator clears, position increments.
  - Reaches −TRANSITIONS_PER_STEP: `step_down` pulses, accumulator clears, position decrements.
  - A partial detent that reverses cancels out; no pulse.
- **Saturation:**
  - Position never leaves [POS_MIN, POS_MAX].
  - A step at a limit still pulses `step_up`/`step_down`; position holds.
- **`enable` low:**
  - Synchroniser, debouncer and `ab_q` keep tracking, so re-enabling causes no spurious step.
  - Accumulator is held at 0; no step pulses; position holds.
  - `error` still reports.
- **Reset mid-operation:** all state returns to its reset values immediately. If the pins rest at 00, at most one `error` pulse follows release; this is accepted.

## Timing
- **Latency:** a pin change held stable is first sampled at edge 0. The debounced value updates at edge DEBOUNCE_CYCLES+1. `position` and the pulse outputs update at edge DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges after the change.
- **Glitch filtering:** a pin glitch lasting fewer than DEBOUNCE_CYCLES synchronised cycles never reaches the decoder.
- **Pulse width:** `step_up`, `step_down` and `error` are exactly one cycle wide and never assert together.
- **Timing closure:** no combinational path from inputs to outputs.
- **Throughput:** at most one decoded transition per cycle. Practical minimum spacing between pin edges is DEBOUNCE_CYCLES+1 cycles.
- **A and B in the same cycle:** if debounced A and B change on the same cycle, the change is an illegal transition (see `error`), even if both raw pins moved close together.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TRANSITIONS_PER_STEP=4 unless noted.

1. Reset asserted mid-run, then released with pins at 11 → `position`=14, no pulses for 20 cycles.
2. Pins driven 11→01→00→10→11, each level held 10 cycles → exactly one `step_up`, 7 cycles after the final edge; `position`=15. The reverse sequence returns `position` to 14 with one `step_down`.
3. A pulsed low for 3 cycles, 5 times, B held 1 → no `step_up`/`step_down`/`error` pulse; `position`=14.
4. 20 clockwise detents from reset → 20 `step_up` pulses; `position` saturates at 28. Then 40 counter-clockwise detents → `position`=0.
5. Both pins switched 11→00 in the same cycle and held → one `error` pulse; `position` and accumulator unchanged. The following sequence 00→10→11 plus a full forward detent steps normally.
6. Half detent forward (11→01→00) then back (00→01→11) → no pulse. `enable`=0 during a full forward detent → no pulse, `position` unchanged. After re-enable, the next detent gives exactly one `step_up`.
